// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the sequenced nibble-based 8x8 multiplier.
// Product-placement helper lives here so the datapath reads as select -> shift -> add.
package approx_mul_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int RES_W  = 16;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    MODE_EXACT   = 2'd0,
    MODE_NO_LL   = 2'd1,
    MODE_HH_ONLY = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_HH = 2'd0,
    SEL_HL = 2'd1,
    SEL_LH = 2'd2,
    SEL_LL = 2'd3
  } sel_e;

  // Places an 8-bit nibble product at the weight its operand nibbles carry.
  function automatic logic [RES_W-1:0] place_pp(input logic [2*NIB_W-1:0] pp,
                                                input sel_e sel);
    logic [RES_W-1:0] placed;
    case (sel)
      SEL_HH:         placed = {pp, 8'h00};
      SEL_HL, SEL_LH: placed = {4'h0, pp, 4'h0};
      default:        placed = {8'h00, pp};
    endcase
    return placed;
  endfunction

endpackage

// File: rtl/nibble_mul4.sv
// Exact combinational 4x4 -> 8-bit unsigned multiplier; the one shared
// multiplier that every partial product of the sequencer passes through.
module nibble_mul4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [7:0] p_o
);

  assign p_o = {4'h0, x_i} * {4'h0, y_i};

endmodule

// File: rtl/approx_mul8_seq.sv
// Sequenced 8x8 unsigned multiplier: one nibble partial product per clock,
// with the accuracy mode trimming the low-significance tail of the schedule.
module approx_mul8_seq
  import approx_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, b_q;
  mode_e              mode_q;
  logic [STEP_W-1:0]  step_q;
  logic [RES_W-1:0]   acc_q;
  logic [RES_W-1:0]   result_q;

  logic               accept;
  logic               last_step;
  logic [STEP_W-1:0]  final_step;
  sel_e               sel;
  logic [NIB_W-1:0]   mul_x, mul_y;
  logic [2*NIB_W-1:0] pp;
  logic [RES_W-1:0]   pp_placed;
  logic [RES_W-1:0]   acc_sum;

  assign accept = in_valid && in_ready;

  // Dropped products are always at the tail of HH,HL,LH,LL, so a mode only
  // shortens the schedule and the step index maps straight onto a select.
  always_comb begin
    final_step = 2'd3;
    case (mode_q)
      MODE_NO_LL:   final_step = 2'd2;
      MODE_HH_ONLY: final_step = 2'd0;
      default:      final_step = 2'd3;
    endcase
  end

  always_comb begin
    sel = SEL_LL;
    case (step_q)
      2'd0:    sel = SEL_HH;
      2'd1:    sel = SEL_HL;
      2'd2:    sel = SEL_LH;
      default: sel = SEL_LL;
    endcase
  end

  assign last_step = (step_q == final_step);

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    mul_x = a_q[3:0];
    mul_y = b_q[3:0];
    case (sel)
      SEL_HH: begin mul_x = a_q[7:4]; mul_y = b_q[7:4]; end
      SEL_HL: begin mul_x = a_q[7:4]; mul_y = b_q[3:0]; end
      SEL_LH: begin mul_x = a_q[3:0]; mul_y = b_q[7:4]; end
      default: begin mul_x = a_q[3:0]; mul_y = b_q[3:0]; end
    endcase
  end

  nibble_mul4 u_nibble_mul4 (
    .x_i (mul_x),
    .y_i (mul_y),
    .p_o (pp)
  );

  assign pp_placed = place_pp(pp, sel);
  assign acc_sum   = acc_q + pp_placed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = MUL;
      MUL:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // result_q is separate from the accumulator so the visible result only
  // moves on the edge that completes an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_EXACT;
      step_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode_e'(mode);
      step_q <= '0;
      acc_q  <= '0;
    end else if (state_q == MUL) begin
      acc_q  <= acc_sum;
      step_q <= step_q + 2'd1;
      if (last_step) result_q <= acc_sum;
    end
  end

  assign result = result_q;

endmodule
